// File: rtl/ecc_87_enc_pipe.sv
// SECDED write-side encoder: one-deep registered pipe with a lockstep duplicate encoder.
// Optional error injection on the stored payload is built when ECC_ERR_INJ_EN is defined.

// Hamming columns over positions 1..N (check bits at powers of two) plus overall parity.
module ecc_87_cal #(
  parameter int DATA_WIDTH   = 87,
  parameter int PARITY_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    bypass,
  output logic [PARITY_WIDTH-1:0] parity_out
);
  localparam int HAM_W = PARITY_WIDTH - 1;

  // Data bit d occupies the d-th non-power-of-two codeword position, starting at 3.
  function automatic logic [DATA_WIDTH-1:0] col_mask(input int sel);
    logic [DATA_WIDTH-1:0] m;
    int pos;
    m   = '0;
    pos = 1;
    for (int d = 0; d < DATA_WIDTH; d++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      m[d] = ((pos >> sel) & 1) != 0;
    end
    return m;
  endfunction

  logic [HAM_W-1:0] ham;
  logic             overall;

  for (genvar gi = 0; gi < HAM_W; gi++) begin : g_ham
    localparam logic [DATA_WIDTH-1:0] MASK = col_mask(gi);
    assign ham[gi] = ^(data_in & MASK);
  end

  assign overall    = (^data_in) ^ (^ham);
  assign parity_out = bypass ? '0 : {overall, ham};
endmodule

module ecc_87_enc_pipe #(
  parameter int DATA_WIDTH   = 87,
  parameter int PARITY_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  output logic                    out_fault,
  input  logic                    fault_detc_en,
  input  logic                    fault_clr,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [7:0]              fault_cnt
`ifdef ECC_ERR_INJ_EN
  ,
  input  logic                    inj_sbit,
  input  logic                    inj_dbit,
  output logic                    inj_armed
`endif
);
  logic [PARITY_WIDTH-1:0] parity0;
  logic [PARITY_WIDTH-1:0] parity1;
  logic                    accept;
  logic                    mismatch;
  logic [DATA_WIDTH-1:0]   data_next;

  logic                    out_valid_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic [PARITY_WIDTH-1:0] out_parity_reg;
  logic                    out_fault_reg;
  logic                    ecc_fault_reg;
  logic                    sticky_reg;
  logic [7:0]              cnt_reg;

  ecc_87_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal0 (
    .data_in    (in_data),
    .bypass     (1'b0),
    .parity_out (parity0)
  );

  ecc_87_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal1 (
    .data_in    (in_data),
    .bypass     (1'b0),
    .parity_out (parity1)
  );

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign mismatch = accept && fault_detc_en && (parity0 != parity1);

`ifdef ECC_ERR_INJ_EN
  logic       armed_reg;
  logic       armed_dbit_reg;
  logic [1:0] flip;

  // A request in the accepting cycle hits the current beat; double-bit wins over single.
  always_comb begin
    flip = 2'b00;
    if (armed_reg || inj_sbit || inj_dbit)
      flip = (armed_dbit_reg || inj_dbit) ? 2'b11 : 2'b01;
  end

  assign data_next = in_data ^ {{(DATA_WIDTH-2){1'b0}}, flip};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_reg      <= 1'b0;
      armed_dbit_reg <= 1'b0;
    end else if (accept) begin
      armed_reg      <= 1'b0;
      armed_dbit_reg <= 1'b0;
    end else if (inj_sbit || inj_dbit) begin
      armed_reg      <= 1'b1;
      armed_dbit_reg <= armed_dbit_reg || inj_dbit;
    end
  end

  assign inj_armed = armed_reg;
`else
  assign data_next = in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_parity_reg <= '0;
      out_fault_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      out_data_reg   <= data_next;
      out_parity_reg <= parity0;
      out_fault_reg  <= mismatch;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  // A clear coinciding with a mismatch restarts the status at one event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ecc_fault_reg <= 1'b0;
      sticky_reg    <= 1'b0;
      cnt_reg       <= 8'd0;
    end else begin
      ecc_fault_reg <= mismatch;
      if (fault_clr) begin
        sticky_reg <= mismatch;
        cnt_reg    <= mismatch ? 8'd1 : 8'd0;
      end else if (mismatch) begin
        sticky_reg <= 1'b1;
        if (cnt_reg != 8'hFF)
          cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_parity   = out_parity_reg;
  assign out_fault    = out_fault_reg;
  assign ecc_fault    = ecc_fault_reg;
  assign fault_sticky = sticky_reg;
  assign fault_cnt    = cnt_reg;
endmodule
